// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns and scan-state encoding shared by the
// seven_seg_scan display stage and its decoder.
package seg7_pkg;

  // Logical (active-high) segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Per-slot scan phase: anodes dark, then the selected digit lit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: digit/control inputs and pin-level outputs of the
// multiplexed 7-segment display stage. master = digit source, slave = display.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    hold;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp_mask, hold,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits, dp_mask, hold,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high segment pattern; values 10-15 show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-segment 7-segment driver.
// Digits are snapshotted once per full scan (tear-free), hold freezes the
// snapshot, and each digit slot starts with a short all-anodes-off interval.
// Optional: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst,
  seven_seg_scan_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_DIGITS-1:0][3:0] digits_in;
  logic [CW-1:0]              cnt_q;
  logic [IW-1:0]              idx_q;
  scan_state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0] snap_q;
  logic [NUM_DIGITS-1:0]      dp_snap_q;
  logic                       slot_wrap, frame_wrap;
  logic [3:0]                 cur_digit;
  logic [6:0]                 dec_seg;
  logic [6:0]                 seg_d, seg_q;
  logic                       dp_d, dp_q;
  logic [NUM_DIGITS-1:0]      an_d, an_q;
  logic                       frame_q;

  assign digits_in  = bus.digits;
  assign slot_wrap  = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);

  // Slot counter and digit index; idx steps once per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_wrap) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_d, blank_q;
  logic                  zero_run;

  // Walk down from the most significant digit; blank while all seen so far are zero.
  always_comb begin
    zero_run = 1'b1;
    blank_d  = '0;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      zero_run = zero_run & (digits_in[NUM_DIGITS-1-j] == 4'd0);
      blank_d[NUM_DIGITS-1-j] = zero_run;
    end
  end
`endif

  // Frame snapshot: captured at the wrap to digit 0 unless hold freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q    <= '0;
      dp_snap_q <= '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      blank_q   <= '0;
`endif
    end else if (frame_wrap && !bus.hold) begin
      snap_q    <= digits_in;
      dp_snap_q <= bus.dp_mask;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BLANK;
    else     state_q <= state_d;
  end

  // Next scan state: light the digit after the blank interval, go dark at slot wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_ON;
      ST_ON:    if (slot_wrap)           state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  assign cur_digit = snap_q[idx_q];

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Logical pin values for the current state and digit.
  always_comb begin
    an_d  = '0;
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (state_q == ST_ON) begin
      an_d[idx_q] = 1'b1;
      seg_d       = dec_seg;
      dp_d        = dp_snap_q[idx_q];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (blank_q[idx_q]) begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
      end
`endif
    end
  end

  // Output register; pin polarity is applied here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG_OFF ^ SEG_POL;
      dp_q    <= DP_POL;
      an_q    <= AN_POL;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d ^ SEG_POL;
      dp_q    <= dp_d ^ DP_POL;
      an_q    <= an_d ^ AN_POL;
      frame_q <= frame_wrap;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed vectors for seven_seg_scan with REFRESH_DIV=4,
// BLANK_CYCLES=1, NUM_DIGITS=4, ACTIVE_LOW=0. Each frame is 16 cycles; the
// pins show, per slot, 1 blank cycle then 3 lit cycles, frame_start on the
// last lit cycle of slot 3.
module tb_seven_seg_scan;

  logic clk = 1'b0;
  logic rst;

  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp_mask;
    logic [3:0][6:0] seg;   // expected seg for slot k at seg[k]
    logic [3:0]      dp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advance to the next frame_start pulse, bounded.
  task automatic wait_frame();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    total_cnt++;
    if (found) pass_cnt++;
    else $display("FAIL frame_wait: frame_start not seen, expected within 40 cycles");
  endtask

  // Called on a frame_start cycle; checks the 16 cycles of the following frame.
  task automatic check_frame(input string tag, input logic [3:0][6:0] seg,
                             input logic [3:0] dp, input int change_at,
                             input logic [15:0] new_digits);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      logic [12:0] exp_v;
      logic [12:0] act_v;
      int k;
      int ph;
      @(negedge clk);
      k  = (cyc - 1) / 4;
      ph = (cyc - 1) % 4;
      if (ph == 0) exp_v = 13'h0;
      else         exp_v = {(cyc == 16), 4'(1 << k), seg[k], dp[k]};
      act_v = {bus.frame_start, bus.an, bus.seg, bus.dp};
      check($sformatf("%s_c%0d {fs,an,seg,dp}", tag, cyc), 32'(act_v), 32'(exp_v));
      if (cyc == change_at) bus.digits = new_digits;
    end
  endtask

  // Reset for 3 cycles with pins dark, then the first frame shows all zeros.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("%s_in_reset%0d {fs,an,seg,dp}", tag, i),
            32'({bus.frame_start, bus.an, bus.seg, bus.dp}), 32'h0);
    end
    rst = 1'b0;
    check_frame({tag, "_zeros"}, {4{7'h3F}}, 4'b0000, 0, 16'h0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
    vecs[1] = '{16'h7B90, 4'b0100, {7'h07, 7'h40, 7'h6F, 7'h3F}, 4'b0100};
    vecs[2] = '{16'hFEA8, 4'b1001, {7'h40, 7'h40, 7'h40, 7'h7F}, 4'b1001};
    vecs[3] = '{16'h5678, 4'b0010, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0010};
    vecs[4] = '{16'h3210, 4'b0000, {7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'b0000};

    bus.digits  = 16'h1234;
    bus.dp_mask = '0;
    bus.hold    = 1'b0;
    rst         = 1'b1;

    do_reset("reset");
    check_frame("scan_1234", vecs[0].seg, vecs[0].dp, 0, 16'h0);

    for (int i = 0; i < 5; i++) begin
      bus.digits  = vecs[i].digits;
      bus.dp_mask = vecs[i].dp_mask;
      wait_frame();
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, 0, 16'h0);
    end

    // Mid-frame digit change must not appear until the next frame.
    check_frame("tear_old", vecs[4].seg, 4'b0000, 6, 16'h5678);
    check_frame("tear_new", vecs[3].seg, 4'b0000, 0, 16'h0);

    // Hold across a wrap keeps the old snapshot; release captures at the next wrap.
    bus.hold   = 1'b1;
    bus.digits = 16'h9999;
    check_frame("hold_a", vecs[3].seg, 4'b0000, 0, 16'h0);
    bus.hold = 1'b0;
    check_frame("hold_b", vecs[3].seg, 4'b0000, 0, 16'h0);
    check_frame("hold_rel", {4{7'h6F}}, 4'b0000, 0, 16'h0);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    bus.digits  = 16'h0050;
    bus.dp_mask = 4'b1111;
    wait_frame();
    check_frame("lz_0050", {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0011, 0, 16'h0);
    bus.digits  = 16'h0000;
    bus.dp_mask = 4'b0000;
    wait_frame();
    check_frame("lz_0000", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 0, 16'h0);
`endif

    // Reset in the middle of a slot clears snapshot and scan position.
    bus.digits = 16'h8888;
    repeat (6) @(negedge clk);
    do_reset("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
